// File: rtl/g2b_pkg.sv
// Shared definitions for the Gray-code receive path: FSM state encoding and
// Gray/binary helper functions usable by both RTL and benches.
package g2b_pkg;

    // Helpers work on a fixed maximum width; callers zero-extend and truncate.
    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] code_t;

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_TRACK = 2'b01
    } g2b_state_e;

    // Zero-extended input gives the correct result for any narrower width.
    function automatic code_t gray2bin(input code_t g);
        code_t b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic code_t bin2gray(input code_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input code_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/g2b_sync.sv
// Multi-bit flip-flop synchroniser for a Gray-coded bus; only one bit changes
// per step, so per-bit synchronisation cannot produce an incoherent code.
module g2b_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_to_bin_decoder.sv
// Gray-code receiver: synchronises gray_in, emits one classified event per code change
// on a single-entry valid/ready buffer. Optional pos_cnt port via G2B_POS_COUNT_EN.
module gray_to_bin_decoder
    import g2b_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             dir_up,
    output logic             step_err,
    output logic             overrun,
    input  logic             clr_ovr
`ifdef G2B_POS_COUNT_EN
    ,
    output logic signed [15:0] pos_cnt
`endif
);

    localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0] gs;
    logic [WIDTH-1:0] last_g_q;
    logic [CntW-1:0]  cnt_q;
    g2b_state_e       state_q;

    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] bin_last;
    logic             multi_bit;
    logic             is_up;
    logic             event_new;
    logic             fire;

    g2b_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_in),
        .q     (gs)
    );

    // Step classifier against the last accepted code.
    always_comb begin
        bin_new   = WIDTH'(gray2bin(MAX_WIDTH'(gs)));
        bin_last  = WIDTH'(gray2bin(MAX_WIDTH'(last_g_q)));
        multi_bit = popcount(MAX_WIDTH'(gs ^ last_g_q)) > 1;
        is_up     = !multi_bit && (bin_new == bin_last + WIDTH'(1));
        event_new = (state_q == S_TRACK) && (gs != last_g_q);
        fire      = out_valid && out_ready;
    end

    // Waits until the synchroniser holds a post-reset sample, then learns the baseline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            last_g_q <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    if (cnt_q == CntW'(SYNC_STAGES)) begin
                        last_g_q <= gs;
                        state_q  <= S_TRACK;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                S_TRACK: begin
                    if (event_new) begin
                        last_g_q <= gs;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
            dir_up    <= 1'b0;
            step_err  <= 1'b0;
        end else if (event_new) begin
            out_valid <= 1'b1;
            bin_out   <= bin_new;
            dir_up    <= is_up;
            step_err  <= multi_bit;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

    // Overwrite of an unaccepted event takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (event_new && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

`ifdef G2B_POS_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt <= '0;
        end else if (event_new && !multi_bit) begin
            pos_cnt <= is_up ? pos_cnt + 16'sd1 : pos_cnt - 16'sd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_to_bin_decoder.sv
// Scoreboard bench for gray_to_bin_decoder (WIDTH=4, SYNC_STAGES=2); expected events
// are queued at stimulus time and popped by a monitor on each accepted output.
module tb_gray_to_bin_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] bin_out;
    logic       dir_up;
    logic       step_err;
    logic       overrun;
    logic       clr_ovr;
`ifdef G2B_POS_COUNT_EN
    logic signed [15:0] pos_cnt;
    logic signed [15:0] pos_before;
`endif

    typedef struct packed {
        logic [3:0] bin;
        logic       up;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   lat;

    gray_to_bin_decoder #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .dir_up    (dir_up),
        .step_err  (step_err),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
`ifdef G2B_POS_COUNT_EN
        ,
        .pos_cnt   (pos_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] g);
        @(posedge clk);
        #1 gray_in = g;
    endtask

    task automatic push(input logic [3:0] b, input logic up, input logic err);
        exp_t e;
        e.bin = b;
        e.up  = up;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: every accepted event must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got bin=%0d up=%0b err=%0b expected none",
                         bin_out, dir_up, step_err);
            end else begin
                e = exp_q.pop_front();
                if ({bin_out, dir_up, step_err} !== {e.bin, e.up, e.err}) begin
                    errors++;
                    $display("FAIL event: got bin=%0d up=%0b err=%0b expected bin=%0d up=%0b err=%0b",
                             bin_out, dir_up, step_err, e.bin, e.up, e.err);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        gray_in   = 4'b0000;
        out_ready = 1'b1;
        clr_ovr   = 1'b0;
        #1;
        check("reset_state", {31'd0, out_valid} | {27'd0, bin_out, dir_up}, 32'd0);
        check("reset_flags", {30'd0, step_err, overrun}, 32'd0);
        wait_cyc(3);
        #1 rst_n = 1'b1;
        wait_cyc(8);
        #1 check("no_baseline_event", {31'd0, out_valid}, 32'd0);

        // 1: first step and its latency
        drive(4'b0001);
        push(4'd1, 1'b1, 1'b0);
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, 32'd3);
        wait_cyc(4);

        // 2: jump to 15 (illegal), then wrap up and wrap down
        drive(4'b1000); push(4'd15, 1'b0, 1'b1); wait_cyc(6);
        drive(4'b0000); push(4'd0,  1'b1, 1'b0); wait_cyc(6);
        drive(4'b1000); push(4'd15, 1'b0, 1'b0); wait_cyc(6);
        drive(4'b0000); push(4'd0,  1'b1, 1'b0); wait_cyc(6);

        // 3: illegal two-bit change, then two down steps
`ifdef G2B_POS_COUNT_EN
        pos_before = pos_cnt;
`endif
        drive(4'b0011); push(4'd2, 1'b0, 1'b1); wait_cyc(6);
`ifdef G2B_POS_COUNT_EN
        check("pos_cnt_illegal", 32'(pos_cnt), 32'(pos_before));
`endif
        drive(4'b0001); push(4'd1, 1'b0, 1'b0); wait_cyc(6);
        drive(4'b0000); push(4'd0, 1'b0, 1'b0); wait_cyc(6);

        // 4: backpressure with overwrite, then drain and clear
        #1 out_ready = 1'b0;
        drive(4'b0001); wait_cyc(6);
        #1 check("held_bin", {28'd0, bin_out}, 32'd1);
        check("no_overrun_yet", {31'd0, overrun}, 32'd0);
        drive(4'b0011); push(4'd2, 1'b1, 1'b0); wait_cyc(6);
        #1 check("overwrite_bin", {28'd0, bin_out}, 32'd2);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("drop_after_fire", {31'd0, out_valid}, 32'd0);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        check("overrun_cleared", {31'd0, overrun}, 32'd0);

        // 5: accept held event on the same edge a new event loads
        out_ready = 1'b0;
        drive(4'b0010); push(4'd3, 1'b1, 1'b0); wait_cyc(6);
        drive(4'b0110); push(4'd4, 1'b1, 1'b0);
        wait_cyc(2);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 check("fire_and_load_valid", {31'd0, out_valid}, 32'd1);
        check("fire_and_load_bin", {28'd0, bin_out}, 32'd4);
        check("fire_and_load_no_ovr", {31'd0, overrun}, 32'd0);
        wait_cyc(4);

        // 6: asynchronous reset with an event pending
        #1 out_ready = 1'b0;
        drive(4'b0111); wait_cyc(5);
        #1 check("pending_before_reset", {30'd0, out_valid, dir_up}, 32'd3);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {26'd0, out_valid, bin_out, dir_up}, 32'd0);
        gray_in = 4'b0110;
        out_ready = 1'b1;
        wait_cyc(2);
        #1 rst_n = 1'b1;
        wait_cyc(10);
        #1 check("no_event_after_reset", {31'd0, out_valid}, 32'd0);
`ifdef G2B_POS_COUNT_EN
        check("pos_cnt_reset", 32'(pos_cnt), 32'd0);
`endif
        drive(4'b0111); push(4'd5, 1'b1, 1'b0); wait_cyc(6);
`ifdef G2B_POS_COUNT_EN
        check("pos_cnt_final", 32'(pos_cnt), 32'd1);
`endif

        wait_cyc(4);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
